// File: rtl/ram_port_arbiter.sv
// Grants one of NUM_MASTERS valid/ready requesters access to a single-port RAM,
// one RAM cycle per grant, with fixed or round-robin priority and an optional bus lock.
module ram_port_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_MASTERS-1:0]                m_valid,
  input  logic [NUM_MASTERS-1:0]                m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]                m_ready,
  output logic [DATA_WIDTH-1:0]                 m_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]        grant_idx,
  output logic                                  ram_cs,
  output logic                                  ram_wren,
  output logic [ADDR_WIDTH-1:0]                 ram_addr,
  output logic [DATA_WIDTH-1:0]                 ram_wdata,
  output logic [DATA_WIDTH/8-1:0]               ram_wstrb,
  input  logic [DATA_WIDTH-1:0]                 ram_rdata
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                 r_state;
  logic [GW-1:0]          r_grant_idx;
  logic [GW-1:0]          r_rr_last;
  logic                   r_lock_active;
  logic [NUM_MASTERS-1:0] r_ready;
  logic                   r_ram_cs;
  logic                   r_ram_wren;
  logic [SW-1:0]          r_ram_wstrb;

  logic [ADDR_WIDTH-1:0]  w_addr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_wdata [NUM_MASTERS];
  logic [SW-1:0]          w_wstrb [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_addr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_wstrb[gi] = m_wstrb[gi*SW +: SW];
    end
  endgenerate

  // Returns {found, index}; round-robin search starts just after base.
  function automatic logic [GW:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [GW-1:0] base);
    logic          found;
    logic [GW-1:0] idx;
    int            k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (PRIORITY_MODE == 0) k = i;
      else                    k = (int'(base) + 1 + i) % NUM_MASTERS;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = GW'(k);
      end
    end
    return {found, idx};
  endfunction

  logic [NUM_MASTERS-1:0] w_grant_onehot;
  logic                   w_lock_eff;
  logic [NUM_MASTERS-1:0] w_idle_req;
  logic [NUM_MASTERS-1:0] w_done_req;
  logic [GW:0]            w_idle_pick;
  logic [GW:0]            w_done_pick;

  assign w_grant_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_grant_idx;
  // A lock held by an owner that has gone quiet is dropped in the same IDLE cycle.
  assign w_lock_eff     = r_lock_active & (m_lock[r_grant_idx] | m_valid[r_grant_idx]);
  assign w_idle_req     = w_lock_eff ? (m_valid & w_grant_onehot) : m_valid;
  assign w_done_req     = m_valid & ~w_grant_onehot;
  assign w_idle_pick    = f_pick(w_idle_req, r_rr_last);
  assign w_done_pick    = f_pick(w_done_req, r_grant_idx);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_grant_idx   <= '0;
      r_rr_last     <= GW'(NUM_MASTERS - 1);
      r_lock_active <= 1'b0;
      r_ready       <= '0;
      r_ram_cs      <= 1'b0;
      r_ram_wren    <= 1'b0;
      r_ram_wstrb   <= '0;
    end else begin
      r_ready     <= '0;
      r_ram_cs    <= 1'b0;
      r_ram_wren  <= 1'b0;
      r_ram_wstrb <= '0;
      case (r_state)
        S_IDLE: begin
          r_lock_active <= w_lock_eff;
          if (w_idle_pick[GW]) begin
            r_grant_idx <= w_idle_pick[GW-1:0];
            r_state     <= S_ACCESS;
            r_ram_cs    <= 1'b1;
            r_ram_wren  <= |w_wstrb[w_idle_pick[GW-1:0]];
            r_ram_wstrb <= w_wstrb[w_idle_pick[GW-1:0]];
          end
        end
        S_ACCESS: begin
          r_state <= S_DONE;
          r_ready <= w_grant_onehot;
        end
        S_DONE: begin
          r_lock_active <= m_lock[r_grant_idx];
          if (PRIORITY_MODE == 1) r_rr_last <= r_grant_idx;
          if (!m_lock[r_grant_idx] && w_done_pick[GW]) begin
            r_grant_idx <= w_done_pick[GW-1:0];
            r_state     <= S_ACCESS;
            r_ram_cs    <= 1'b1;
            r_ram_wren  <= |w_wstrb[w_done_pick[GW-1:0]];
            r_ram_wstrb <= w_wstrb[w_done_pick[GW-1:0]];
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_ready   = r_ready;
  assign m_rdata   = ram_rdata;
  assign grant_idx = r_grant_idx;
  assign ram_cs    = r_ram_cs;
  assign ram_wren  = r_ram_wren;
  assign ram_wstrb = r_ram_wstrb;
  assign ram_addr  = w_addr[r_grant_idx];
  assign ram_wdata = w_wdata[r_grant_idx];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a 2-master fixed-priority arbiter with a byte-strobed RAM model,
// and a 4-master round-robin arbiter whose RAM returns the accessed address.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  a_valid, a_lock, a_ready;
  logic [27:0] a_addr;
  logic [63:0] a_wdata;
  logic [7:0]  a_wstrb;
  logic [31:0] a_rdata, a_rwdata, a_rrdata;
  logic [0:0]  a_gidx;
  logic        a_cs, a_wren;
  logic [13:0] a_raddr;
  logic [3:0]  a_rwstrb;

  logic [3:0]   b_valid, b_lock, b_ready;
  logic [55:0]  b_addr;
  logic [127:0] b_wdata;
  logic [15:0]  b_wstrb;
  logic [31:0]  b_rdata, b_rwdata, b_rrdata;
  logic [1:0]   b_gidx;
  logic         b_cs, b_wren;
  logic [13:0]  b_raddr;
  logic [3:0]   b_rwstrb;

  ram_port_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(14), .DATA_WIDTH(32), .PRIORITY_MODE(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .m_valid(a_valid), .m_lock(a_lock), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_wstrb(a_wstrb), .m_ready(a_ready), .m_rdata(a_rdata),
    .grant_idx(a_gidx), .ram_cs(a_cs), .ram_wren(a_wren), .ram_addr(a_raddr),
    .ram_wdata(a_rwdata), .ram_wstrb(a_rwstrb), .ram_rdata(a_rrdata));

  ram_port_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(14), .DATA_WIDTH(32), .PRIORITY_MODE(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .m_valid(b_valid), .m_lock(b_lock), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_wstrb(b_wstrb), .m_ready(b_ready), .m_rdata(b_rdata),
    .grant_idx(b_gidx), .ram_cs(b_cs), .ram_wren(b_wren), .ram_addr(b_raddr),
    .ram_wdata(b_rwdata), .ram_wstrb(b_rwstrb), .ram_rdata(b_rrdata));

  logic [31:0] mem_a [0:255];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_cs) begin
      if (a_wren) mem_a[a_raddr[7:0]] <= merge(mem_a[a_raddr[7:0]], a_rwdata, a_rwstrb);
      a_rrdata <= mem_a[a_raddr[7:0]];
    end
  end

  always @(posedge clk) if (b_cs) b_rrdata <= {18'h0, b_raddr};

  always @(negedge clk) begin
    if (a_ready != 2'b00) $display("A done: ready=%b grant=%0d rdata=0x%08h", a_ready, a_gidx, a_rdata);
    if (b_ready != 4'b0000) $display("B done: ready=%b grant=%0d rdata=0x%08h", b_ready, b_gidx, b_rdata);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] e2;
    logic [3:0] e4;
    a_valid = '0; a_lock = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = '0; b_lock = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
    mem_a[8'h10] = 32'hAAAA0010;
    mem_a[8'h20] = 32'hBBBB0020;
    mem_a[8'h05] = 32'h12345678;

    // Reset state
    tick(); tick();
    chk("rst_cs", a_cs, 0);
    chk("rst_wren", a_wren, 0);
    chk("rst_wstrb", a_rwstrb, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_gidx", a_gidx, 0);
    chk("rst_b_gidx", b_gidx, 0);
    chk("rst_b_cs", b_cs, 0);
    reset_n = 1'b1;

    // Two simultaneous reads, fixed priority
    a_addr = {14'h20, 14'h10}; a_valid = 2'b11;
    tick();
    chk("t1_acc0_cs", a_cs, 1);
    chk("t1_acc0_addr", a_raddr, 14'h10);
    chk("t1_acc0_ready", a_ready, 0);
    tick();
    chk("t1_ready0", a_ready, 2'b01);
    chk("t1_rdata0", a_rdata, 32'hAAAA0010);
    chk("t1_done_cs", a_cs, 0);
    a_valid = 2'b10;
    tick();
    chk("t1_acc1_cs", a_cs, 1);
    chk("t1_acc1_addr", a_raddr, 14'h20);
    chk("t1_acc1_gidx", a_gidx, 1);
    chk("t1_acc1_ready", a_ready, 0);
    tick();
    chk("t1_ready1", a_ready, 2'b10);
    chk("t1_rdata1", a_rdata, 32'hBBBB0020);
    a_valid = 2'b00;

    // Idle bus
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_cs", a_cs, 0);
      chk("idle_ready", a_ready, 0);
      chk("idle_gidx", a_gidx, 1);
    end

    // Partial write then read back
    a_addr = {14'h0, 14'h05}; a_wdata = {32'h0, 32'hDEADBEEF}; a_wstrb = 8'h03; a_valid = 2'b01;
    tick();
    chk("wr_wren", a_wren, 1);
    chk("wr_wstrb", a_rwstrb, 4'h3);
    chk("wr_wdata", a_rwdata, 32'hDEADBEEF);
    chk("wr_addr", a_raddr, 14'h05);
    tick();
    chk("wr_ready", a_ready, 2'b01);
    a_wstrb = 8'h00;
    tick();
    chk("rd_idle_cs", a_cs, 0);
    chk("rd_idle_ready", a_ready, 0);
    tick();
    chk("rd_cs", a_cs, 1);
    chk("rd_wren", a_wren, 0);
    chk("rd_wstrb", a_rwstrb, 0);
    tick();
    chk("rd_ready", a_ready, 2'b01);
    chk("rd_rdata", a_rdata, 32'h1234BEEF);
    a_valid = 2'b00;
    tick();

    // Single master continuously valid in fixed mode: one completion every 3 cycles
    a_addr = {14'h20, 14'h10}; a_valid = 2'b01;
    for (int c = 1; c <= 9; c++) begin
      tick();
      e2 = (c % 3 == 2) ? 2'b01 : 2'b00;
      chk("fix_ready", a_ready, e2);
    end
    a_valid = 2'b00;
    tick();

    // Master 1 locks the bus over 4 reads while master 0 waits
    a_valid = 2'b10; a_lock = 2'b10;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 2 || c == 5 || c == 8 || c == 11) e2 = 2'b10;
      else if (c == 13)                          e2 = 2'b01;
      else                                       e2 = 2'b00;
      chk("lock_ready", a_ready, e2);
      if (c == 12) chk("lock_gidx", a_gidx, 0);
      if (c == 13) chk("lock_rdata0", a_rdata, 32'hAAAA0010);
      if (c == 1)  a_valid[0] = 1'b1;
      if (c == 9)  a_lock[1] = 1'b0;
      if (c == 11) a_valid[1] = 1'b0;
      if (c == 13) a_valid[0] = 1'b0;
    end
    tick();

    // Reset during the ACCESS cycle of a read
    a_addr = {14'h0, 14'h10}; a_valid = 2'b01;
    tick();
    chk("mrst_acc_cs", a_cs, 1);
    reset_n = 1'b0;
    tick();
    chk("mrst_cs", a_cs, 0);
    chk("mrst_ready", a_ready, 0);
    reset_n = 1'b1;
    tick();
    chk("mrst_reacc_cs", a_cs, 1);
    chk("mrst_reacc_ready", a_ready, 0);
    tick();
    chk("mrst_ready_after", a_ready, 2'b01);
    chk("mrst_rdata", a_rdata, 32'hAAAA0010);
    a_valid = 2'b00;
    tick();

    // Round robin, 4 masters continuously valid
    b_addr = {14'h103, 14'h102, 14'h101, 14'h100}; b_valid = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c % 2 == 0) begin
        e4 = 4'(1 << ((c / 2 - 1) % 4));
        chk("rr_ready", b_ready, e4);
        chk("rr_rdata", b_rdata, 64'(32'h100 + ((c / 2 - 1) % 4)));
      end else begin
        chk("rr_gidx", b_gidx, 64'(((c - 1) / 2) % 4));
        chk("rr_cs", b_cs, 1);
        chk("rr_acc_ready", b_ready, 0);
      end
    end
    b_valid = 4'h0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
